axis_switch_ctrl: RTL and testbench
===================================

# axis_switch_ctrl

Packet-sequencing controller for the two-output AXI-stream switch. It accepts routing commands of the form {destination, beat count}, drives the switch's `port_select`, and gates the upstream TVALID/TREADY pair so that exactly the commanded number of beats reaches the selected output. `port_select` never changes mid-packet. TDATA bypasses this block and is wired straight from the upstream source to the switch.

## Interface

- `LEN_W`, default 16. Width of the beat-count field; one command covers 1..2^LEN_W beats.
- `clk`  in  1  Sole clock.
- `reset`  in  1  Synchronous, active-high.
- `cmd_tdata`  in  LEN_W+1  Routing command. Bit [LEN_W] is the destination port (0/1). Bits [LEN_W-1:0] are the beat count minus one.
- `cmd_tvalid`  in  1  Command valid.
- `cmd_tready`  out  1  Command accepted.
- `s_tvalid`  in  1  Upstream data TVALID.
- `s_tready`  out  1  Upstream data TREADY (gated).
- `sw_tvalid`  out  1  To the switch input TVALID (gated).
- `sw_tready`  in  1  From the switch input TREADY.
- `port_select`  out  1  To the switch `port_select`; registered.
- `busy`  out  1  High while a command is active.
- `pkt_done`  out  1  One-cycle pulse on the final beat's handshake.
- `pkt_count0`, `pkt_count1`  out  32 each  Completed packets per port. Present only with the stats macro defined.

## Operation

- States: IDLE, ROUTE.
- IDLE:
  - `sw_tvalid` = 0, `s_tready` = 0, `cmd_tready` = 1.
  - On `cmd_tvalid`: load `port_select` ← cmd[LEN_W] and `remaining` ← cmd[LEN_W-1:0], then go to ROUTE.
- ROUTE:
  - `sw_tvalid` = `s_tvalid`; `s_tready` = `sw_tready`.
  - A beat is a cycle where `s_tvalid & sw_tready`.
  - Each beat with `remaining` ≠ 0 decrements `remaining`.
  - The beat with `remaining` = 0 is the last beat: `pkt_done` = 1 that cycle.
- Back-to-back commands:
  - `cmd_tready` = 1 during ROUTE only on the last-beat cycle.
  - If `cmd_tvalid` is also high that cycle, load the new command and stay in ROUTE. There is no bubble.
  - Otherwise return to IDLE.
- `busy` = (state == ROUTE).
- Width rule: `remaining` is LEN_W bits and never underflows. The count-minus-one encoding makes a zero-length command unrepresentable.
- Upstream beats presented while in IDLE are held off (`s_tready` = 0); none are lost.
- Reset, including mid-packet:
  - State → IDLE, `port_select` = 0, `remaining` = 0, `busy` = 0, `pkt_done` = 0, counters = 0.
  - The rest of the in-flight packet is abandoned. Upstream must also be reset.

## Timing

- `port_select` and state are registered.
- `sw_tvalid`, `s_tready`, `cmd_tready` and `pkt_done` are combinational from state plus the current handshake inputs.
- Command accepted at cycle t → `port_select` valid and gate open from t+1. First beat can complete at t+1.
- Last beat at cycle t with a new command accepted the same cycle → new `port_select` from t+1 with zero idle cycles.
- The `s_tready`/`sw_tready` and `s_tvalid`/`sw_tvalid` paths are combinational, so there is no added data latency.
- `s_tvalid` must not depend on `s_tready`, per AXI-stream rules.

## Configuration

- Macro: `AXIS_SWITCH_CTRL_STATS_EN`.
- Defined: `pkt_count0`/`pkt_count1` exist. Each increments by 1 on `pkt_done` for the current `port_select`, and wraps at 2^32 to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure

- Shared package `axis_switch_pkg`:
  - State enum {IDLE, ROUTE}.
  - Command field localparams: destination bit index = LEN_W, count slice = [LEN_W-1:0].
  - Stats counter width, 32.
- No sub-module is needed. If a sub-module is wanted, make the stats counter pair a separate `axis_switch_stats` sub-module.
- Instantiated beside `axis_switch`. `sw_tvalid`/`sw_tready`/`port_select` connect to the switch's `axis_in_tvalid`/`axis_in_tready`/`port_select`.

## Test plan

- Reset then idle with `s_tvalid` = 1 → `s_tready` = 0, `sw_tvalid` = 0, `port_select` = 0, `busy` = 0 for 10 cycles.
- Cmd {dest=1, count=3} with `sw_tready` held high → exactly 4 beats pass. `port_select` = 1 from the cycle after acceptance. `pkt_done` pulses on beat 4. Return to IDLE the next cycle.
- Cmds {0, 1} and {1, 0} presented back-to-back → 2 beats to port 0, then 1 beat to port 1 in the immediately following cycle. `cmd_tready` is high on the last-beat cycle.
- Cmd {0, 7} with `sw_tready` toggling every other cycle and random `s_tvalid` gaps → exactly 8 handshakes, and `port_select` is stable throughout.
- `reset` asserted after 2 of 5 beats → next cycle shows IDLE, `port_select` = 0 and `busy` = 0. Counters read 0 with `AXIS_SWITCH_CTRL_STATS_EN`.
- With stats enabled, three packets to port 1 and one to port 0 → `pkt_count1` = 3, `pkt_count0` = 1.

Source files
------------

// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-stream switch sequencing controller.
package axis_switch_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUTE = 1'b1;

  localparam int unsigned STATS_W = 32;

  // Command layout: {destination, beat count minus one}.
  function automatic int unsigned cmd_dest_bit(input int unsigned len_w);
    return len_w;
  endfunction

  function automatic int unsigned cmd_cnt_msb(input int unsigned len_w);
    return len_w - 1;
  endfunction

endpackage

// File: rtl/axis_switch_ctrl.sv
// Packet-sequencing controller: routes exactly the commanded beat count to one switch port.
// Optional per-port packet counters are enabled with `define AXIS_SWITCH_CTRL_STATS_EN.
module axis_switch_ctrl
  import axis_switch_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W:0]   cmd_tdata,
  input  logic             cmd_tvalid,
  output logic             cmd_tready,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             sw_tvalid,
  input  logic             sw_tready,
  output logic             port_select,
  output logic             busy,
  output logic             pkt_done
`ifdef AXIS_SWITCH_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_count0,
  output logic [STATS_W-1:0] pkt_count1
`endif
);

  localparam int unsigned DEST_BIT = cmd_dest_bit(LEN_W);
  localparam int unsigned CNT_MSB  = cmd_cnt_msb(LEN_W);

  logic [0:0]       state_q, state_d;
  logic             port_select_q, port_select_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic in_route;
  logic beat;
  logic last_beat;
  logic load;

  always_comb begin
    in_route   = (state_q == ROUTE);
    beat       = in_route & s_tvalid & sw_tready;
    last_beat  = beat & (remaining_q == '0);
    cmd_tready = ~in_route | last_beat;
    load       = cmd_tvalid & cmd_tready;
    sw_tvalid  = in_route & s_tvalid;
    s_tready   = in_route & sw_tready;
    pkt_done   = last_beat;
    busy       = in_route;
  end

  always_comb begin
    state_d       = state_q;
    port_select_d = port_select_q;
    remaining_d   = remaining_q;
    // A new command on the last beat reloads in place, so no idle cycle is inserted.
    if (load) begin
      state_d       = ROUTE;
      port_select_d = cmd_tdata[DEST_BIT];
      remaining_d   = cmd_tdata[CNT_MSB:0];
    end else if (last_beat) begin
      state_d = IDLE;
    end else if (beat) begin
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      port_select_q <= 1'b0;
      remaining_q   <= '0;
    end else begin
      state_q       <= state_d;
      port_select_q <= port_select_d;
      remaining_q   <= remaining_d;
    end
  end

  assign port_select = port_select_q;

`ifdef AXIS_SWITCH_CTRL_STATS_EN
  logic [STATS_W-1:0] pkt_count0_q, pkt_count0_d;
  logic [STATS_W-1:0] pkt_count1_q, pkt_count1_d;

  always_comb begin
    pkt_count0_d = pkt_count0_q;
    pkt_count1_d = pkt_count1_q;
    if (last_beat) begin
      if (port_select_q) pkt_count1_d = pkt_count1_q + STATS_W'(1);
      else               pkt_count0_d = pkt_count0_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
    end else begin
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
    end
  end

  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
`endif

endmodule

// File: tb/tb_axis_switch_ctrl.sv
// Self-checking bench for axis_switch_ctrl: cycle model plus per-packet beat scoreboard.
module tb_axis_switch_ctrl;

  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW:0]   cmd_tdata;
  logic          cmd_tvalid;
  logic          cmd_tready;
  logic          s_tvalid;
  logic          s_tready;
  logic          sw_tvalid;
  logic          sw_tready;
  logic          port_select;
  logic          busy;
  logic          pkt_done;
`ifdef AXIS_SWITCH_CTRL_STATS_EN
  logic [31:0]   pkt_count0;
  logic [31:0]   pkt_count1;
`endif

  axis_switch_ctrl #(.LEN_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_tdata   (cmd_tdata),
    .cmd_tvalid  (cmd_tvalid),
    .cmd_tready  (cmd_tready),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .sw_tvalid   (sw_tvalid),
    .sw_tready   (sw_tready),
    .port_select (port_select),
    .busy        (busy),
    .pkt_done    (pkt_done)
`ifdef AXIS_SWITCH_CTRL_STATS_EN
    ,
    .pkt_count0  (pkt_count0),
    .pkt_count1  (pkt_count1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic [LW-1:0] cnt;
  } cmd_t;

  typedef struct {
    logic port;
    int   beats;
  } exp_t;

  cmd_t pend_q[$];
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic          m_busy = 1'b0;
  logic          m_port = 1'b0;
  logic [LW-1:0] m_rem  = '0;
  int            m_cnt0 = 0;
  int            m_cnt1 = 0;
  int            beat_cnt = 0;

  // 0: s_tvalid high, 1: random, 2: held low
  int   s_mode   = 0;
  // 0: sw_tready high, 1: toggling
  int   rdy_mode = 0;
  logic rdy_tog  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cmd_tvalid = (pend_q.size() != 0);
    cmd_tdata  = (pend_q.size() != 0) ? {pend_q[0].port, pend_q[0].cnt} : '0;
    case (s_mode)
      0:       s_tvalid = 1'b1;
      1:       s_tvalid = 1'($urandom_range(0, 1));
      default: s_tvalid = 1'b0;
    endcase
    rdy_tog   = ~rdy_tog;
    sw_tready = (rdy_mode == 0) ? 1'b1 : rdy_tog;
  endtask

  // Sample one cycle at the falling edge, check, advance the model, then drive the next cycle.
  task automatic step();
    logic m_beat, m_last, m_crdy;
    exp_t e;
    @(negedge clk);
    m_beat = m_busy && s_tvalid && sw_tready;
    m_last = m_beat && (m_rem == '0);
    m_crdy = !m_busy || m_last;

    chk("busy",        64'(busy),        64'(m_busy));
    chk("port_select", 64'(port_select), 64'(m_port));
    chk("sw_tvalid",   64'(sw_tvalid),   64'(m_busy && s_tvalid));
    chk("s_tready",    64'(s_tready),    64'(m_busy && sw_tready));
    chk("cmd_tready",  64'(cmd_tready),  64'(m_crdy));
    chk("pkt_done",    64'(pkt_done),    64'(m_last));

    if (sw_tvalid && sw_tready) beat_cnt++;
    if (pkt_done) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_port",  64'(port_select), 64'(e.port));
        chk("sb_beats", 64'(beat_cnt),    64'(e.beats));
      end
      beat_cnt = 0;
    end

    if (m_last) begin
      if (m_port) m_cnt1++;
      else        m_cnt0++;
    end

    if (reset) begin
      m_busy = 1'b0;
      m_port = 1'b0;
      m_rem  = '0;
      m_cnt0 = 0;
      m_cnt1 = 0;
      beat_cnt = 0;
      exp_q.delete();
    end else if (cmd_tvalid && m_crdy) begin
      m_busy = 1'b1;
      m_port = cmd_tdata[LW];
      m_rem  = cmd_tdata[LW-1:0];
      exp_q.push_back('{port: cmd_tdata[LW], beats: int'(cmd_tdata[LW-1:0]) + 1});
      void'(pend_q.pop_front());
    end else if (m_last) begin
      m_busy = 1'b0;
    end else if (m_beat) begin
      m_rem = m_rem - LW'(1);
    end

    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (pend_q.size() == 0 && !m_busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic send(input logic port, input int cnt);
    pend_q.push_back('{port: port, cnt: LW'(cnt)});
    drive();
  endtask

  initial begin
    logic reached;
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    // Idle with upstream valid: nothing may pass
    s_mode = 0;
    rdy_mode = 0;
    drive();
    for (int i = 0; i < 10; i++) step();

    // Single 4-beat packet to port 1
    send(1'b1, 3);
    run_until_idle("drain_single", 50);
    step();

    // Back-to-back 2 beats to port 0 then 1 beat to port 1
    send(1'b0, 1);
    send(1'b1, 0);
    run_until_idle("drain_b2b", 50);
    step();

    // 8 beats under throttled ready and gappy valid
    s_mode = 1;
    rdy_mode = 1;
    send(1'b0, 7);
    run_until_idle("drain_throttled", 200);
    s_mode = 0;
    rdy_mode = 0;
    drive();
    step();

    // Reset after 2 of 5 beats
    send(1'b1, 4);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (beat_cnt == 2) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    chk("reset_setup", 64'(reached), 64'd1);
    s_mode = 2;
    drive();
    reset = 1'b1;
    step();
    reset = 1'b0;
    s_mode = 0;
    drive();
    step();
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_port", 64'(port_select), 64'd0);
`ifdef AXIS_SWITCH_CTRL_STATS_EN
    chk("post_reset_cnt0", 64'(pkt_count0), 64'd0);
    chk("post_reset_cnt1", 64'(pkt_count1), 64'd0);

    send(1'b1, 2);
    send(1'b0, 0);
    send(1'b1, 1);
    send(1'b1, 0);
    run_until_idle("drain_stats", 100);
    step();
    chk("pkt_count0", 64'(pkt_count0), 64'(m_cnt0));
    chk("pkt_count1", 64'(pkt_count1), 64'(m_cnt1));
    chk("pkt_count0_abs", 64'(pkt_count0), 64'd1);
    chk("pkt_count1_abs", 64'(pkt_count1), 64'd3);
`endif

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
